// File: rtl/bc_mac_seq.sv
// Bit-serial dot-product MAC: one weight bit-plane per cycle, LSB first, with valid/ready I/O.
// Define BC_MAC_SIGNED_EN for two's-complement weights (MSB plane subtracts); default is unsigned.

module bc_mac_lane #(
  parameter int ABITS = 4,
  parameter int WBITS = 8,
  parameter int CW    = 3
) (
  input  logic [ABITS-1:0] i_act,
  input  logic [WBITS-1:0] i_wt,
  input  logic [CW-1:0]    i_sel,
  output logic [ABITS-1:0] o_p
);
  assign o_p = i_wt[i_sel] ? i_act : '0;
endmodule

module bc_mac_seq #(
  parameter  int LANES = 8,
  parameter  int ABITS = 4,
  parameter  int WBITS = 8,
  localparam int LOG2L = $clog2(LANES),
  localparam int RW    = ABITS + WBITS + LOG2L + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ABITS-1:0] act,
  input  logic [LANES*WBITS-1:0] weight,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          result,
  output logic                   busy
);
  localparam int PW = ABITS + LOG2L;
  localparam int AW = PW + 1;
  localparam int CW = $clog2(WBITS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   r_state, w_state_nx;
  logic [LANES*ABITS-1:0]   r_act;
  logic [LANES*WBITS-1:0]   r_wt;
  logic [AW-1:0]            r_acc;
  logic [WBITS-1:0]         r_trunc;
  logic [CW-1:0]            r_cnt;
  logic [RW-1:0]            r_result;

  logic [LANES-1:0][ABITS-1:0] w_lane;
  logic [PW-1:0]            w_plane;
  logic [AW:0]              w_acc_x, w_p_x, w_sum;
  logic                     w_sub, w_last, w_accept;

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign result    = r_result;
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_cnt == CW'(WBITS-1));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bc_mac_lane #(.ABITS(ABITS), .WBITS(WBITS), .CW(CW)) u_lane (
      .i_act (r_act[i*ABITS +: ABITS]),
      .i_wt  (r_wt[i*WBITS +: WBITS]),
      .i_sel (r_cnt),
      .o_p   (w_lane[i])
    );
  end

  always_comb begin
    w_plane = '0;
    for (int i = 0; i < LANES; i++) w_plane = w_plane + PW'(w_lane[i]);
  end

  // Sum is one bit wider than acc so the pre-shift value never wraps.
`ifdef BC_MAC_SIGNED_EN
  assign w_sub   = w_last;
  assign w_acc_x = {r_acc[AW-1], r_acc};
`else
  assign w_sub   = 1'b0;
  assign w_acc_x = {1'b0, r_acc};
`endif
  assign w_p_x = (AW+1)'(w_plane);
  assign w_sum = w_sub ? (w_acc_x - w_p_x) : (w_acc_x + w_p_x);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nx = S_RUN;
      S_RUN:   if (w_last) w_state_nx = S_DONE;
      S_DONE:  if (out_ready) w_state_nx = in_valid ? S_RUN : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_act    <= '0;
      r_wt     <= '0;
      r_acc    <= '0;
      r_trunc  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_act   <= act;
        r_wt    <= weight;
        r_acc   <= '0;
        r_trunc <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_acc   <= w_sum[AW:1];
        r_trunc <= {w_sum[0], r_trunc[WBITS-1:1]};
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) r_result <= {w_sum[AW:1], w_sum[0], r_trunc[WBITS-1:1]};
      end
    end
  end
endmodule
